// File: rtl/ifetch_line_buffer_pkg.sv
// Shared widths, line geometry and fetch FSM encodings for the instruction-fetch line buffer.
package ifetch_line_buffer_pkg;

    localparam int unsigned ADDR_WIDTH       = 32;
    localparam int unsigned BENCH_WIDTH      = 128;
    localparam int unsigned LINE_OFFSET_BITS = 4;
    localparam int unsigned WORD_W           = 32;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_DRAIN = 2'd2
    } if_state_e;

endpackage

// File: rtl/ifetch_line_buffer.sv
// Instruction-fetch front end: fetches 128-bit lines from mem_ctrl port 1, holds one line,
// and streams 32-bit instructions to decode in program order with redirect support.
module ifetch_line_buffer
    import ifetch_line_buffer_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_WIDTH,
    parameter int unsigned       LINE_W   = BENCH_WIDTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              read_op1,
    output logic [ADDR_W-1:0] addr1,
    input  logic [LINE_W-1:0] data1_o,
    input  logic              busy1,
    input  logic              done1
);

    localparam int unsigned TAG_W = ADDR_W - LINE_OFFSET_BITS;
    localparam int unsigned WORDS = LINE_W / WORD_W;

    if_state_e                     state_q, state_d;
    logic [ADDR_W-1:0]             pc_q, pc_d;
    logic [WORDS-1:0][WORD_W-1:0]  buf_q, buf_d;
    logic [TAG_W-1:0]              tag_q, tag_d;
    logic                          buf_valid_q, buf_valid_d;
    logic                          read_q, read_d;
    logic [ADDR_W-1:0]             addr_q, addr_d;

    logic                          hit;
    logic [ADDR_W-1:0]             redir_pc;
    logic                          unused_inputs;

    // busy1 is advisory only: a request simply waits for done1.
    assign unused_inputs = ^{busy1, redirect_pc[1:0]};

    assign hit      = buf_valid_q && (tag_q == pc_q[ADDR_W-1:LINE_OFFSET_BITS]);
    assign redir_pc = {redirect_pc[ADDR_W-1:2], 2'b00};

    // All outputs come from registered state only.
    assign inst_valid = (state_q == IF_IDLE) && hit;
    assign inst       = buf_q[pc_q[3:2]];
    assign inst_pc    = pc_q;
    assign read_op1   = read_q;
    assign addr1      = addr_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IF_IDLE;
            pc_q        <= RESET_PC;
            buf_q       <= '0;
            tag_q       <= '0;
            buf_valid_q <= 1'b0;
            read_q      <= 1'b0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_q       <= buf_d;
            tag_q       <= tag_d;
            buf_valid_q <= buf_valid_d;
            read_q      <= read_d;
            addr_q      <= addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_d       = buf_q;
        tag_d       = tag_q;
        buf_valid_d = buf_valid_q;
        read_d      = read_q;
        addr_d      = addr_q;

        unique case (state_q)
            IF_IDLE: begin
                if (redirect) begin
                    pc_d        = redir_pc;
                    buf_valid_d = 1'b0;
                end else if (!hit) begin
                    state_d = IF_FETCH;
                    read_d  = 1'b1;
                    addr_d  = {pc_q[ADDR_W-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
                end else if (inst_ready) begin
                    pc_d = pc_q + ADDR_W'(4);
                end
            end

            IF_FETCH: begin
                if (done1) begin
                    read_d  = 1'b0;
                    state_d = IF_IDLE;
                    // A redirect landing with the data drops the line outright.
                    if (redirect) begin
                        pc_d        = redir_pc;
                        buf_valid_d = 1'b0;
                    end else begin
                        buf_d       = data1_o;
                        tag_d       = addr_q[ADDR_W-1:LINE_OFFSET_BITS];
                        buf_valid_d = 1'b1;
                    end
                end else if (redirect) begin
                    pc_d        = redir_pc;
                    buf_valid_d = 1'b0;
                    state_d     = IF_DRAIN;
                end
            end

            IF_DRAIN: begin
                if (redirect) begin
                    pc_d        = redir_pc;
                    buf_valid_d = 1'b0;
                end
                if (done1) begin
                    read_d  = 1'b0;
                    state_d = IF_IDLE;
                end
            end

            default: begin
                state_d = IF_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ifetch_line_buffer.sv
// Directed and randomized checks of ifetch_line_buffer against a program-order reference
// model and a latency-programmable memory responder.
module tb_ifetch_line_buffer;
    import ifetch_line_buffer_pkg::*;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 128;

    logic          CLK = 1'b0;
    logic          RST;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          inst_valid;
    logic [31:0]   inst;
    logic [AW-1:0] inst_pc;
    logic          inst_ready;
    logic          read_op1;
    logic [AW-1:0] addr1;
    logic [LW-1:0] data1_o;
    logic          busy1;
    logic          done1;

    ifetch_line_buffer #(
        .ADDR_W   (AW),
        .LINE_W   (LW),
        .RESET_PC (32'h0)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .read_op1    (read_op1),
        .addr1       (addr1),
        .data1_o     (data1_o),
        .busy1       (busy1),
        .done1       (done1)
    );

    always #5 CLK = ~CLK;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] ref_pc   = 32'h0;
    bit          prev_redirect = 1'b0;
    bit          mem_pending   = 1'b0;
    int          mem_cnt       = 0;
    logic [31:0] mem_addr      = 32'h0;
    int          mem_lat       = 3;
    bit          mem_rand      = 1'b0;
    int          n_req         = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        return (wa * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] la);
        return {word_of(la + 32'd12), word_of(la + 32'd8), word_of(la + 32'd4), word_of(la)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory responder: one request at a time, done1 pulses mem_cnt cycles after acceptance.
    task automatic mem_step();
        if (RST) begin
            mem_pending = 1'b0;
            done1       = 1'b0;
            busy1       = 1'b0;
            return;
        end
        done1   = 1'b0;
        data1_o = {$urandom, $urandom, $urandom, $urandom};
        if (mem_pending) begin
            chk("read_op1_held", read_op1, 32'd1);
            chk("addr1_held", addr1, mem_addr);
        end else if (read_op1 === 1'b1) begin
            chk("addr1_aligned", addr1 & 32'hF, 32'h0);
            chk("addr1_is_pc_line", addr1, {ref_pc[31:4], 4'h0});
            mem_pending = 1'b1;
            mem_addr    = addr1;
            mem_cnt     = mem_rand ? int'($urandom_range(1, 5)) : mem_lat;
            n_req++;
        end
        if (mem_pending) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                done1       = 1'b1;
                data1_o     = line_of(mem_addr);
                mem_pending = 1'b0;
            end
        end
        busy1 = mem_pending;
    endtask

    task automatic clk_cycle();
        bit          acc, rd, rs;
        logic [31:0] tgt;
        acc = (inst_valid === 1'b1) && inst_ready && !redirect;
        rd  = redirect;
        rs  = RST;
        tgt = {redirect_pc[31:2], 2'b00};
        @(posedge CLK);
        if (rs)       ref_pc = 32'h0;
        else if (rd)  ref_pc = tgt;
        else if (acc) ref_pc = ref_pc + 32'd4;
        @(negedge CLK);
        mem_step();
        if (!rs) begin
            if (rd) chk("valid_after_redirect", inst_valid, 32'd0);
            if (inst_valid === 1'b1) begin
                chk("inst_pc", inst_pc, ref_pc);
                chk("inst", inst, word_of(ref_pc));
            end
        end
        prev_redirect = rd;
    endtask

    task automatic wait_valid(input string tag, input int maxc, output int k);
        k = 0;
        while (inst_valid !== 1'b1 && k < maxc) begin
            clk_cycle();
            k++;
        end
        chk(tag, inst_valid, 32'd1);
    endtask

    task automatic wait_req(input string tag, input int maxc);
        int k;
        k = 0;
        while (read_op1 !== 1'b1 && k < maxc) begin
            clk_cycle();
            k++;
        end
        chk(tag, read_op1, 32'd1);
    endtask

    task automatic wait_req_drop(input string tag, input int maxc);
        int k;
        k = 0;
        while (read_op1 === 1'b1 && k < maxc) begin
            clk_cycle();
            k++;
        end
        chk(tag, read_op1, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          k;
        int          r0;
        logic [31:0] held_inst;

        RST = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
        done1 = 1'b0; busy1 = 1'b0; data1_o = '0;
        clk_cycle();
        clk_cycle();
        chk("rst_read_op1", read_op1, 32'd0);
        chk("rst_addr1", addr1, 32'h0);
        chk("rst_inst_valid", inst_valid, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'h0);

        // 1: cold fetch, four sequential words, then next line
        RST = 1'b0;
        clk_cycle();
        chk("t1_read_op1", read_op1, 32'd1);
        chk("t1_addr1", addr1, 32'h0);
        wait_valid("t1_valid", 10, k);
        chk("t1_fill_latency", k, 32'd3);
        for (int i = 0; i < 4; i++) begin
            chk("t1_seq_valid", inst_valid, 32'd1);
            chk("t1_seq_pc", inst_pc, 32'(i * 4));
            clk_cycle();
        end
        chk("t1_line_cross_miss", inst_valid, 32'd0);
        clk_cycle();
        chk("t1_next_read", read_op1, 32'd1);
        chk("t1_next_addr", addr1, 32'h10);

        // 2: stall with a hit
        wait_valid("t2_valid", 10, k);
        chk("t2_pc", inst_pc, 32'h10);
        inst_ready = 1'b0;
        held_inst  = inst;
        r0 = n_req;
        for (int i = 0; i < 5; i++) begin
            clk_cycle();
            chk("t2_stall_valid", inst_valid, 32'd1);
            chk("t2_stall_pc", inst_pc, 32'h10);
            chk("t2_stall_inst", inst, held_inst);
            chk("t2_no_read", read_op1, 32'd0);
        end
        chk("t2_req_count", n_req, r0);
        inst_ready = 1'b1;

        // 3: redirect while fetching 0x20
        k = 0;
        while (!(read_op1 === 1'b1 && addr1 == 32'h20) && k < 20) begin
            clk_cycle();
            k++;
        end
        chk("t3_fetch_0x20", addr1, 32'h20);
        r0 = n_req;
        redirect = 1'b1; redirect_pc = 32'h107;
        clk_cycle();
        redirect = 1'b0;
        chk("t3_drain_read_held", read_op1, 32'd1);
        chk("t3_drain_addr_held", addr1, 32'h20);
        chk("t3_drain_valid", inst_valid, 32'd0);
        wait_req_drop("t3_drain_done", 10);
        wait_req("t3_new_req", 4);
        chk("t3_new_addr", addr1, 32'h100);
        chk("t3_req_count", n_req, r0 + 1);
        wait_valid("t3_valid", 10, k);
        chk("t3_first_pc", inst_pc, 32'h104);

        // 3b: redirect into the same line being fetched must still refetch
        redirect = 1'b1; redirect_pc = 32'h400;
        clk_cycle();
        redirect = 1'b0;
        clk_cycle();
        chk("t3b_read", read_op1, 32'd1);
        chk("t3b_addr", addr1, 32'h400);
        redirect = 1'b1; redirect_pc = 32'h408;
        clk_cycle();
        redirect = 1'b0;
        wait_req_drop("t3b_drain_done", 10);
        wait_req("t3b_refetch", 4);
        chk("t3b_refetch_addr", addr1, 32'h400);
        wait_valid("t3b_valid", 10, k);
        chk("t3b_pc", inst_pc, 32'h408);

        // 4: redirect and accept in the same cycle
        inst_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h200;
        clk_cycle();
        redirect = 1'b0;
        chk("t4_valid_low", inst_valid, 32'd0);
        chk("t4_pc_target", inst_pc, 32'h200);
        clk_cycle();
        chk("t4_read", read_op1, 32'd1);
        chk("t4_addr", addr1, 32'h200);

        // 5: redirect coincident with done1
        k = 0;
        while (done1 !== 1'b1 && k < 10) begin
            clk_cycle();
            k++;
        end
        chk("t5_done_seen", done1, 32'd1);
        r0 = n_req;
        redirect = 1'b1; redirect_pc = 32'h204;
        clk_cycle();
        redirect = 1'b0;
        chk("t5_valid_low", inst_valid, 32'd0);
        chk("t5_read_low", read_op1, 32'd0);
        clk_cycle();
        chk("t5_refetch", read_op1, 32'd1);
        chk("t5_refetch_addr", addr1, 32'h200);
        chk("t5_req_count", n_req, r0 + 1);
        wait_valid("t5_valid", 10, k);
        chk("t5_pc", inst_pc, 32'h204);

        // 6: wrap at top of address space, then reset mid-fetch
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        clk_cycle();
        redirect = 1'b0;
        wait_valid("t6_valid", 10, k);
        chk("t6_top_pc", inst_pc, 32'hFFFF_FFFC);
        clk_cycle();
        chk("t6_wrap_pc", inst_pc, 32'h0);
        chk("t6_wrap_miss", inst_valid, 32'd0);
        clk_cycle();
        chk("t6_wrap_read", read_op1, 32'd1);
        chk("t6_wrap_addr", addr1, 32'h0);
        RST = 1'b1;
        clk_cycle();
        chk("t6_rst_read", read_op1, 32'd0);
        chk("t6_rst_addr", addr1, 32'h0);
        chk("t6_rst_valid", inst_valid, 32'd0);
        chk("t6_rst_inst", inst, 32'h0);
        chk("t6_rst_pc", inst_pc, 32'h0);
        RST = 1'b0;
        wait_valid("t6_after_rst", 12, k);
        chk("t6_after_rst_pc", inst_pc, 32'h0);

        // Random traffic against the program-order model
        mem_rand = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            inst_ready  = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFC0 | ($urandom & 32'h3F))
                                                      : ($urandom & 32'h7FF);
            clk_cycle();
        end
        redirect   = 1'b0;
        inst_ready = 1'b1;
        wait_valid("rand_final_valid", 20, k);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
